spi_instr_loader: RTL and testbench

SPI_INSTR_LOADER -- requirements
Module: spi_instr_loader

---
 rtl/pio_pkg.sv | 23 ++
 rtl/sync_ff.sv | 27 ++
 rtl/spi_instr_loader.sv | 165 ++++++++++++++++
 tb/tb_spi_instr_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared constants and types for the PIO instruction-loading path.
`timescale 1ns/1ps
package pio_pkg;

    localparam int INSTR_W     = 16;
    localparam int IMEM_ADDR_W = 5;

    // Command opcode that opens a write frame; every other opcode is ignored.
    localparam logic [2:0] OP_WRITE = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_IGNORE
    } spi_state_t;

    // Opcode field of a command byte {op[2:0], addr[4:0]}.
    function automatic logic [2:0] cmd_op(input logic [7:0] cmd);
        return cmd[7:5];
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
`timescale 1ns/1ps
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; reset to the bus idle level.
    // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_instr_loader.sv
// SPI (mode 0) slave that writes 16-bit instruction words into the
// instruction regfile, with auto-incrementing write pointer.
`timescale 1ns/1ps
module spi_instr_loader
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic [INSTR_W-1:0]     instr_in,
    output logic [IMEM_ADDR_W-1:0] write_addr,
    output logic                   write_en,
    output logic                   load_active
);

    localparam int FW = $clog2(SYNC_STAGES + 1);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_q, cs_n_q;
    logic [FW-1:0] flush_cnt;
    logic flushed, armed;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_state_t state, state_next;
    logic [3:0]             bit_cnt;
    logic [IMEM_ADDR_W-1:0] ptr;
    logic [6:0]             cmd_sr;
    logic [14:0]            data_sr;
    logic [6:0]             miso_sr;
    logic [7:0]             cmd_next;
    logic [15:0]            word_next;
    logic [7:0]             miso_byte;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_n_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
    );

    // The synchronizer reset value is not a real observation of CS, so a
    // frame may only open once CS has actually been seen high after reset;
    // a CS held low through reset therefore never starts a frame.
    assign flushed = (flush_cnt == FW'(SYNC_STAGES));

    // Edge-detect history and the post-reset arming of CS falling edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            cs_n_q <= cs_n_s;
            if (!flushed) flush_cnt <= flush_cnt + 1'b1;
            if (flushed && cs_n_s) armed <= 1'b1;
        end
    end

    assign cs_fall   = armed & cs_n_q & ~cs_n_s;
    assign cs_rise   = ~cs_n_q & cs_n_s;
    assign sclk_rise = sclk_s & ~sclk_q & ~cs_n_s;
    assign sclk_fall = ~sclk_s & sclk_q & ~cs_n_s;

    assign cmd_next  = {cmd_sr, mosi_s};
    assign word_next = {data_sr, mosi_s};
    assign miso_byte = {3'b000, ptr};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: CS release always returns to IDLE.
    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall) state_next = ST_CMD;
                ST_CMD: begin
                    if (sclk_rise && bit_cnt == 4'd7)
                        state_next = (cmd_op(cmd_next) == OP_WRITE) ? ST_DATA : ST_IGNORE;
                end
                default: state_next = state;
            endcase
        end
    end

    // Shift registers, bit counter, write pointer, MISO and regfile strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            ptr        <= '0;
            cmd_sr     <= '0;
            data_sr    <= '0;
            miso_sr    <= '0;
            instr_in   <= '0;
            write_addr <= '0;
            write_en   <= 1'b0;
            spi_miso   <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (cs_rise) begin
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            bit_cnt  <= '0;
                            cmd_sr   <= '0;
                            data_sr  <= '0;
                            miso_sr  <= miso_byte[6:0];
                            spi_miso <= miso_byte[7];
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= cmd_next[6:0];
                            if (bit_cnt == 4'd7) begin
                                bit_cnt  <= '0;
                                spi_miso <= 1'b0;
                                miso_sr  <= '0;
                                if (cmd_op(cmd_next) == OP_WRITE) ptr <= cmd_next[4:0];
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (sclk_fall) begin
                            spi_miso <= miso_sr[6];
                            miso_sr  <= {miso_sr[5:0], 1'b0};
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            data_sr <= word_next[14:0];
                            bit_cnt <= bit_cnt + 4'd1;  // wraps 15 -> 0 for the next word
                            if (bit_cnt == 4'd15) begin
                                instr_in   <= word_next;
                                write_addr <= ptr;
                                write_en   <= 1'b1;
                                ptr        <= ptr + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign load_active = (state == ST_DATA);

endmodule

// File: tb/tb_spi_instr_loader.sv
// Randomized scoreboard bench for spi_instr_loader.
`timescale 1ns/1ps
module tb_spi_instr_loader;

    localparam int HP = 60;  // SPI half period (clk period is 10)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] instr_in;
    logic [4:0]  write_addr;
    logic        write_en;
    logic        load_active;

    spi_instr_loader #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .instr_in(instr_in), .write_addr(write_addr),
        .write_en(write_en), .load_active(load_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] word;
    } wr_t;

    wr_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [4:0]  m_ptr   = 5'd0;   // reference model of the write pointer
    logic [15:0] tx_words[8];
    logic        prev_we = 1'b0;
    logic [15:0] got_main;
    logic [7:0]  r_cmd;
    int          r_nw, r_pb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mode-0 master: drive MOSI while SCLK low, sample MISO just before rising.
    task automatic xfer(input logic [15:0] val, input int n, output logic [15:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            #(HP);
            got = {got[14:0], spi_miso};
            spi_sclk = 1'b1;
            #(HP);
            spi_sclk = 1'b0;
        end
    endtask

    // One complete frame; expected writes come from the frame rules alone.
    task automatic run_frame(input logic [7:0] cmd, input int nwords, input int partial);
        logic [15:0] got;
        logic [7:0]  exp_miso;
        logic        is_wr;
        exp_miso = {3'b000, m_ptr};
        is_wr    = (cmd[7:5] == 3'b001);
        if (is_wr) m_ptr = cmd[4:0];
        spi_cs_n = 1'b0;
        #100;
        xfer({8'h00, cmd}, 8, got);
        check("miso_cmd", 32'(got[7:0]), 32'(exp_miso));
        check("load_active_frame", 32'(load_active), 32'(is_wr));
        for (int w = 0; w < nwords; w++) begin
            if (is_wr) begin
                exp_q.push_back('{m_ptr, tx_words[w]});
                m_ptr = m_ptr + 5'd1;
            end
            xfer(tx_words[w], 16, got);
            check("miso_data_zero", 32'(spi_miso), 32'd0);
        end
        if (partial > 0) xfer(16'($urandom), partial, got);
        #(HP);
        spi_cs_n = 1'b1;
        #(2 * HP);
        check("load_active_idle", 32'(load_active), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (write_en) begin
            wr_t e;
            check("we_single_cycle", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(write_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(write_addr), 32'(e.addr));
                check("instr_in", 32'(instr_in), 32'(e.word));
            end
        end
        prev_we = write_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        rst = 1'b0;
        #100;
        check("rst_instr_in", 32'(instr_in), 32'd0);
        check("rst_write_addr", 32'(write_addr), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_load_active", 32'(load_active), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);

        // Single write at address 3, then the outputs hold.
        tx_words[0] = 16'hA5C3;
        run_frame(8'h23, 1, 0);
        drain();
        check("hold_instr_in", 32'(instr_in), 32'hA5C3);
        check("hold_write_addr", 32'(write_addr), 32'd3);

        // Pointer wrap 31 -> 0.
        tx_words[0] = 16'h1111;
        tx_words[1] = 16'h2222;
        run_frame(8'h3F, 2, 0);
        drain();

        // Non-write opcode: no strobe, load_active stays low.
        tx_words[0] = 16'h5A5A;
        run_frame(8'h40, 1, 0);
        drain();

        // Partial word discarded, next frame writes at 5.
        run_frame(8'h20, 0, 10);
        tx_words[0] = 16'hBEEF;
        run_frame(8'h25, 1, 0);
        drain();

        // Three writes from 0, then MISO reports the next pointer (3).
        for (int w = 0; w < 3; w++) tx_words[w] = 16'($urandom);
        run_frame(8'h20, 3, 0);
        run_frame(8'h60, 0, 0);
        drain();

        // Reset mid-word with CS held low: nothing happens until CS toggles.
        spi_cs_n = 1'b0;
        #100;
        xfer(16'h0020, 8, got_main);
        check("miso_cmd_before_rst", 32'(got_main[7:0]), {27'd0, m_ptr});
        xfer(16'h1234, 12, got_main);
        rst = 1'b1;
        #50;
        rst = 1'b0;
        m_ptr = 5'd0;
        #100;
        check("post_rst_load_active", 32'(load_active), 32'd0);
        xfer(16'hFFFF, 16, got_main);
        xfer(16'h20AB, 16, got_main);
        check("post_rst_still_idle", 32'(load_active), 32'd0);
        check("post_rst_miso", 32'(spi_miso), 32'd0);
        #(HP);
        spi_cs_n = 1'b1;
        #(2 * HP);
        tx_words[0] = 16'hC0DE;
        run_frame(8'h21, 1, 0);
        drain();

        // Randomized frames: mostly writes, random lengths and truncations.
        for (int f = 0; f < 20; f++) begin
            r_cmd = 8'($urandom);
            if ($urandom_range(0, 9) < 7) r_cmd[7:5] = 3'b001;
            r_nw = int'($urandom_range(0, 3));
            r_pb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : 0;
            for (int w = 0; w < 8; w++) tx_words[w] = 16'($urandom);
            run_frame(r_cmd, r_nw, r_pb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
